rom_loader: RTL and testbench

Consumes the byte stream produced by the MCU-facing system block (`rom_loading`, `rom_do`, `rom_do_valid`) and writes it to external SDRAM as 16-bit little-endian words through a request/acknowledge write port. It buffers up to eight packed words in a FIFO so that SPI byte arrival is decoupled from memory latency. It also captures the first 64 bytes (cartridge header region) in a readable register file and reports load progress, completion and overflow to the core.

---
 rtl/rom_loader.sv | 123 ++++++++++++
 tb/tb_rom_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// rom_loader: packs the ROM byte stream into 16-bit words, buffers them and writes them to SDRAM
module rom_loader #(
  parameter int ADDR_W     = 22,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rom_loading,
  input  logic [7:0]        rom_do,
  input  logic              rom_do_valid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [5:0]        hdr_addr,
  output logic [7:0]        hdr_data,
  output logic [23:0]       byte_count,
  output logic              busy,
  output logic              load_done,
  output logic              overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [24:0] CAP = 25'd1 << (ADDR_W + 1);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;
  typedef enum logic {W_IDLE, W_REQ} wstate_t;
  state_t state, state_n;
  wstate_t wstate, wstate_n;
  logic [ADDR_W-1:0] fa [FIFO_DEPTH];
  logic [15:0] fd [FIFO_DEPTH];
  logic [PW:0] wp, rp;
  logic [7:0] low;
  logic pending;
  logic [7:0] hdr [64];
  logic start, take, at_cap, acc, flush_push, push_req, full, empty, push, pop, done, hdr_we;
  logic [ADDR_W-1:0] push_addr;
  logic [15:0] push_data;
  assign mem_req = wstate == W_REQ;
  assign busy    = state != IDLE;
  // control decode and next-state for both the load FSM and the write engine
  always_comb begin
    start      = state == IDLE && rom_loading;
    take       = state == LOAD && rom_loading && rom_do_valid;
    at_cap     = {1'b0, byte_count} == CAP;
    acc        = take && !at_cap;
    flush_push = state == LOAD && !rom_loading && pending;
    push_req   = (acc && byte_count[0]) || flush_push;
    full       = wp[PW] != rp[PW] && wp[PW-1:0] == rp[PW-1:0];
    empty      = wp == rp;
    push       = push_req && !full;
    pop        = wstate == W_REQ && mem_ack;
    push_addr  = byte_count[ADDR_W:1];
    push_data  = flush_push ? {8'h00, low} : {rom_do, low};
    done       = state == FLUSH && empty && !mem_req;
    hdr_we     = acc && byte_count < 24'd64;
    state_n    = start ? LOAD : (state == LOAD && !rom_loading) ? FLUSH : done ? IDLE : state;
    wstate_n   = (wstate == W_IDLE && !empty) ? W_REQ : pop ? W_IDLE : wstate;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      wstate <= W_IDLE;
    end else begin
      state  <= state_n;
      wstate <= wstate_n;
    end
  end
  // byte packing, counters, FIFO pointers and the write-port registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp         <= '0;
      rp         <= '0;
      low        <= '0;
      pending    <= 1'b0;
      byte_count <= '0;
      overflow   <= 1'b0;
      load_done  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      load_done <= done;
      if (start) begin
        wp         <= '0;
        rp         <= '0;
        pending    <= 1'b0;
        byte_count <= '0;
        overflow   <= 1'b0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
        if ((push_req && full) || (take && at_cap)) overflow <= 1'b1;
        if (acc) begin
          byte_count <= byte_count + 24'd1;
          pending    <= !byte_count[0];
          if (!byte_count[0]) low <= rom_do;
        end
        if (flush_push) pending <= 1'b0;
      end
      if (wstate == W_IDLE && !empty) begin
        mem_addr  <= fa[rp[PW-1:0]];
        mem_wdata <= fd[rp[PW-1:0]];
      end
    end
  end
  // FIFO storage
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (!resetn) begin
        fa[i] <= '0;
        fd[i] <= '0;
      end else if (push && wp[PW-1:0] == PW'(i)) begin
        fa[i] <= push_addr;
        fd[i] <= push_data;
      end
  end
  // header capture with registered, write-forwarding read port
  always_ff @(posedge clk) begin
    for (int i = 0; i < 64; i++)
      if (!resetn || start) hdr[i] <= '0;
      else if (hdr_we && byte_count[5:0] == 6'(i)) hdr[i] <= rom_do;
    hdr_data <= (!resetn || start) ? '0 : (hdr_we && hdr_addr == byte_count[5:0]) ? rom_do : hdr[hdr_addr];
  end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized scoreboard bench for rom_loader
module tb_rom_loader;
  localparam int AW = 22;
  logic clk = 0, resetn = 0, rom_loading = 0, rom_do_valid = 0, mem_ack = 0;
  logic [7:0] rom_do = 0;
  logic [5:0] hdr_addr = 0;
  logic mem_req, busy, load_done, overflow;
  logic [AW-1:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [7:0] hdr_data;
  logic [23:0] byte_count;
  int n_chk = 0, n_fail = 0, done_cnt = 0;
  bit ack_en = 1;
  logic [AW+15:0] sb [$];
  logic [7:0] lb [$];

  rom_loader #(.ADDR_W(AW), .FIFO_DEPTH(8)) dut (
    .clk(clk), .resetn(resetn), .rom_loading(rom_loading), .rom_do(rom_do),
    .rom_do_valid(rom_do_valid), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .hdr_addr(hdr_addr), .hdr_data(hdr_data),
    .byte_count(byte_count), .busy(busy), .load_done(load_done), .overflow(overflow));

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endfunction

  // expected words of a load: consecutive byte pairs, little-endian, odd tail padded with zero
  task automatic model_push(input int max_words);
    for (int w = 0; 2 * w < lb.size() && w < max_words; w++)
      sb.push_back({AW'(w), (2 * w + 1 < lb.size()) ? lb[2 * w + 1] : 8'h00, lb[2 * w]});
  endtask

  // ack driver and write monitor: acks within 0..2 cycles, checks each accepted write
  int wcnt = 0;
  logic [AW+15:0] got_w, exp_w;
  always @(negedge clk) begin
    if (mem_ack) begin
      chk("req_drops_after_ack", mem_req, 0);
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_write got=%h exp=none", got_w);
      end else begin
        exp_w = sb.pop_front();
        chk("write_addr", 32'(got_w[AW+15:16]), 32'(exp_w[AW+15:16]));
        chk("write_data", 32'(got_w[15:0]), 32'(exp_w[15:0]));
      end
    end
    mem_ack = 0;
    if (!mem_req) wcnt = $urandom_range(0, 2);
    else if (ack_en) begin
      if (wcnt == 0) begin
        mem_ack = 1;
        got_w = {mem_addr, mem_wdata};
      end else wcnt--;
    end
  end

  always @(negedge clk)
    if (load_done) begin
      done_cnt++;
      chk("busy_low_with_done", busy, 0);
    end

  task automatic start_load();
    @(negedge clk) rom_loading = 1;
    @(negedge clk);
  endtask

  task automatic send_bytes(input int gap);
    foreach (lb[i]) begin
      rom_do = lb[i];
      rom_do_valid = 1;
      @(negedge clk) rom_do_valid = 0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = load_done;
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL load_done_timeout got=0 exp=1");
    end
  endtask

  task automatic full_load(input int gap);
    model_push(1 << 30);
    start_load();
    send_bytes(gap);
    rom_loading = 0;
    wait_done();
    chk("sb_drained", sb.size(), 0);
    chk("byte_count", byte_count, lb.size());
    chk("overflow_clear", overflow, 0);
  endtask

  task automatic fill(input int n, input bit ramp);
    lb.delete();
    for (int i = 0; i < n; i++) lb.push_back(ramp ? 8'(i) : 8'($urandom));
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_hdr_data", hdr_data, 0);
    chk("rst_byte_count", byte_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_overflow", overflow, 0);
    resetn = 1;
    // four bytes, two words, exactly one load_done
    lb = '{8'h11, 8'h22, 8'h33, 8'h44};
    d0 = done_cnt;
    full_load(2);
    repeat (3) @(negedge clk);
    chk("one_load_done", done_cnt - d0, 1);
    hdr_addr = 2;
    @(negedge clk) chk("hdr_byte2", hdr_data, 8'h33);
    hdr_addr = 10;
    @(negedge clk) chk("hdr_unwritten", hdr_data, 0);
    // odd length: padded final word, done only after its ack
    lb = '{8'hAA, 8'hBB, 8'hCC};
    full_load(3);
    // ack withheld: eight words buffered, the rest dropped
    ack_en = 0;
    fill(20, 0);
    model_push(8);
    start_load();
    send_bytes(0);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", byte_count, 20);
    rom_loading = 0;
    repeat (5) @(negedge clk);
    ack_en = 1;
    wait_done();
    chk("ovf_sb_drained", sb.size(), 0);
    chk("ovf_sticky", overflow, 1);
    fill(6, 0);
    full_load(2);
    // ramp 100 bytes, header readback
    fill(100, 1);
    full_load(2);
    for (int a = 0; a < 64; a++) begin
      hdr_addr = 6'(a);
      @(negedge clk) chk("hdr_read", hdr_data, a);
    end
    // IDLE strobes are ignored
    for (int i = 0; i < 3; i++) begin
      rom_do = 8'hEE;
      rom_do_valid = 1;
      @(negedge clk) rom_do_valid = 0;
    end
    chk("idle_valid_count", byte_count, 100);
    // reset during an outstanding request
    ack_en = 0;
    fill(6, 0);
    start_load();
    send_bytes(2);
    chk("req_before_reset", mem_req, 1);
    resetn = 0;
    rom_loading = 0;
    @(negedge clk);
    chk("rst2_mem_req", mem_req, 0);
    chk("rst2_byte_count", byte_count, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_hdr_data", hdr_data, 0);
    chk("rst2_mem_addr", mem_addr, 0);
    sb.delete();
    resetn = 1;
    ack_en = 1;
    lb = '{8'h5A, 8'hA5};
    full_load(2);
    // FLUSH strobes ignored, reload requested during FLUSH
    ack_en = 0;
    fill(5, 0);
    model_push(1 << 30);
    start_load();
    send_bytes(2);
    rom_loading = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rom_do_valid = 1;
      @(negedge clk) rom_do_valid = 0;
    end
    chk("flush_valid_count", byte_count, 5);
    chk("flush_busy", busy, 1);
    rom_loading = 1;
    ack_en = 1;
    wait_done();
    chk("flush_sb_drained", sb.size(), 0);
    @(negedge clk);
    chk("reload_busy", busy, 1);
    chk("reload_count", byte_count, 0);
    fill(9, 0);
    model_push(1 << 30);
    send_bytes(2);
    rom_loading = 0;
    wait_done();
    chk("reload_drained", sb.size(), 0);
    chk("reload_bytes", byte_count, 9);
    // random loads
    for (int k = 0; k < 4; k++) begin
      fill($urandom_range(1, 80), 0);
      full_load($urandom_range(2, 4));
    end
    repeat (5) @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
